// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative radix-2 multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Fixed latency of WIDTH+2 cycles from acceptance to the valid_o pulse; kill_i aborts at any time.
module zeroriscy_multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         sm_q, sm_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic load, step, fix;

    // Operand magnitudes at acceptance; the most-negative value maps to its unsigned magnitude.
    logic             neg_a_in, neg_b_in;
    logic [WIDTH-1:0] abs_a_in, abs_b_in;
    assign neg_a_in = signed_mode_i[0] & op_a_i[WIDTH-1];
    assign neg_b_in = signed_mode_i[1] & op_b_i[WIDTH-1];
    assign abs_a_in = neg_a_in ? -op_a_i : op_a_i;
    assign abs_b_in = neg_b_in ? -op_b_i : op_b_i;

    logic neg_a_q, neg_b_q;
    assign neg_a_q = sm_q[0] & opa_q[WIDTH-1];
    assign neg_b_q = sm_q[1] & opb_q[WIDTH-1];

    // Multiply: {hi,lo} holds the partial product with the multiplier shifting out of lo.
    // Divide: lo shifts the dividend into the remainder in hi and collects quotient bits.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH+1:0] trial;
    assign add_sum = hi_q + {1'b0, (lo_q[0] ? mag_q : {WIDTH{1'b0}})};
    assign trial   = {hi_q, lo_q[WIDTH-1]} - {2'b00, mag_q};

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s, fix_res;
    logic               div_zero, div_ovf;
    assign prod     = {hi_q[WIDTH-1:0], lo_q};
    assign prod_s   = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quot_s   = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    assign rem_s    = neg_a_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    assign div_zero = (opb_q == {WIDTH{1'b0}});
    assign div_ovf  = (sm_q == 2'b11) && (opa_q == {1'b1, {(WIDTH-1){1'b0}}})
                      && (opb_q == {WIDTH{1'b1}});

    always_comb begin
        fix_res = {WIDTH{1'b0}};
        case (op_q)
            MD_OP_MULL: fix_res = prod_s[WIDTH-1:0];
            MD_OP_MULH: fix_res = prod_s[2*WIDTH-1:WIDTH];
            MD_OP_DIV:  fix_res = div_zero ? {WIDTH{1'b1}} : (div_ovf ? opa_q : quot_s);
            MD_OP_REM:  fix_res = div_zero ? opa_q : (div_ovf ? {WIDTH{1'b0}} : rem_s);
            default:    fix_res = {WIDTH{1'b0}};
        endcase
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (en_i && !kill_i) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == {CNT_W{1'b0}}) state_d = FIX;
                end
            end
            FIX: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    fix     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = !kill_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        sm_d     = sm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mag_d    = mag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        if (load) begin
            op_d  = operator_i;
            sm_d  = signed_mode_i;
            opa_d = op_a_i;
            opb_d = op_b_i;
            cnt_d = CNT_W'(WIDTH - 1);
            hi_d  = {(WIDTH+1){1'b0}};
            mag_d = operator_i[1] ? abs_b_in : abs_a_in;
            lo_d  = operator_i[1] ? abs_a_in : abs_b_in;
        end
        if (step) begin
            cnt_d = (cnt_q == {CNT_W{1'b0}}) ? cnt_q : cnt_q - CNT_W'(1);
            if (!op_q[1]) begin
                hi_d = {1'b0, add_sum[WIDTH:1]};
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end else if (!trial[WIDTH+1]) begin
                hi_d = trial[WIDTH:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
        if (fix) result_d = fix_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 2'b00;
            sm_q     <= 2'b00;
            opa_q    <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            mag_q    <= {WIDTH{1'b0}};
            hi_q     <= {(WIDTH+1){1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sm_q     <= sm_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mag_q    <= mag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_iter.sv
// Scoreboard bench for zeroriscy_multdiv_iter: driver pushes expected result and completion edge,
// a negedge monitor pops and compares on every valid_o pulse.
module tb_zeroriscy_multdiv_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_i;
    logic [1:0]    operator_i;
    logic [1:0]    signed_mode_i;
    logic [W-1:0]  op_a_i;
    logic [W-1:0]  op_b_i;
    logic          kill_i;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  result_o;

    zeroriscy_multdiv_iter #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en_i),
        .operator_i    (operator_i),
        .signed_mode_i (signed_mode_i),
        .op_a_i        (op_a_i),
        .op_b_i        (op_b_i),
        .kill_i        (kill_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .result_o      (result_o)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] res;
        int           edge_no;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference: widen to 64-bit signed according to signed_mode, then use plain arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [1:0] sm,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint      x, y, q, r;
        logic [63:0] p;
        x = sm[0] ? longint'($signed(a)) : longint'(a);
        y = sm[1] ? longint'($signed(b)) : longint'(b);
        if (op == 2'b00 || op == 2'b01) begin
            p = 64'(x * y);
            return (op == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) begin
            q = -1;
            r = longint'(a);
        end else if (sm == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = longint'(a);
            r = 0;
        end else begin
            q = x / y;
            r = x % y;
        end
        p = (op == 2'b10) ? 64'(q) : 64'(r);
        return p[31:0];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: result 0x%08h at edge %0d, no request pending",
                         result_o, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks += 2;
                if (result_o !== e.res) begin
                    fails++;
                    $display("FAIL result id=%0d: got 0x%08h expected 0x%08h", e.id, result_o, e.res);
                end
                if (edge_cnt != e.edge_no) begin
                    fails++;
                    $display("FAIL latency id=%0d: valid at edge %0d expected edge %0d",
                             e.id, edge_cnt, e.edge_no);
                end
            end
        end
    end

    // Called at a negedge while the unit is idle; returns at the negedge after acceptance.
    task automatic start_op(input logic [1:0] op, input logic [1:0] sm, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] expv, input bit push,
                            input int id);
        en_i          = 1'b1;
        operator_i    = op;
        signed_mode_i = sm;
        op_a_i        = a;
        op_b_i        = b;
        @(negedge clk);
        en_i = 1'b0;
        check($sformatf("accept_busy id=%0d", id), {31'b0, ready_o}, 32'h0);
        if (push) sb.push_back('{expv, edge_cnt + W + 1, id});
        operator_i    = 2'($urandom);
        signed_mode_i = 2'($urandom);
        op_a_i        = 32'($urandom);
        op_b_i        = 32'($urandom);
    endtask

    // Waits for ready_o while throwing junk requests at the busy unit.
    task automatic wait_idle(input int id);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (ready_o === 1'b1) begin
                done = 1'b1;
            end else begin
                en_i          = 1'($urandom);
                operator_i    = 2'($urandom);
                signed_mode_i = 2'($urandom);
                op_a_i        = 32'($urandom);
                op_b_i        = 32'($urandom);
                @(negedge clk);
            end
        end
        en_i = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout id=%0d: ready_o stayed 0 expected 1", id);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [1:0]   sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    vec_t dir[11];

    initial begin
        dir[0]  = '{2'b00, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        dir[1]  = '{2'b01, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        dir[2]  = '{2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir[3]  = '{2'b10, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        dir[4]  = '{2'b11, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        dir[5]  = '{2'b10, 2'b00, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF};
        dir[6]  = '{2'b11, 2'b00, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007};
        dir[7]  = '{2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        dir[8]  = '{2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        dir[9]  = '{2'b01, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        dir[10] = '{2'b11, 2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB};

        rst_n         = 1'b0;
        en_i          = 1'b0;
        kill_i        = 1'b0;
        operator_i    = 2'b00;
        signed_mode_i = 2'b00;
        op_a_i        = '0;
        op_b_i        = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, ready_o}, 32'h1);
        check("reset_valid", {31'b0, valid_o}, 32'h0);
        check("reset_result", result_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir[i]) begin
            start_op(dir[i].op, dir[i].sm, dir[i].a, dir[i].b, dir[i].res, 1'b1, i);
            wait_idle(i);
        end

        // Kill in cycle 10, then a fresh request in cycle 11.
        start_op(2'b00, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0, 100);
        repeat (9) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill_ready", {31'b0, ready_o}, 32'h1);
        start_op(2'b10, 2'b11, 32'hFFFF_FF9C, 32'h0000_0007,
                 ref_model(2'b10, 2'b11, 32'hFFFF_FF9C, 32'h0000_0007), 1'b1, 101);
        wait_idle(101);

        // Reset asserted in cycle 5 of a divide, with en_i held high.
        start_op(2'b10, 2'b00, 32'hDEAD_BEEF, 32'h0000_0013, 32'h0, 1'b0, 200);
        repeat (4) @(negedge clk);
        rst_n      = 1'b0;
        en_i       = 1'b1;
        operator_i = 2'b00;
        op_a_i     = 32'h5;
        op_b_i     = 32'h6;
        @(negedge clk);
        check("midrst_ready", {31'b0, ready_o}, 32'h1);
        check("midrst_valid", {31'b0, valid_o}, 32'h0);
        check("midrst_result", result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en_i  = 1'b0;
        @(negedge clk);
        check("midrst_no_accept", {31'b0, ready_o}, 32'h1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]   op, sm;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            sm = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            start_op(op, sm, a, b, ref_model(op, sm, a, b), 1'b1, 300 + n);
            wait_idle(300 + n);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
